serial_addsub: RTL and testbench
================================

# serial_addsub

Parametrised bit-serial adder/subtractor. It computes a WIDTH-bit sum or difference one bit per clock, LSB first, through a single one-bit full-adder cell. Results are reported with carry/borrow and signed overflow flags. The block sits behind the lab datapath's control FSM and trades latency for a constant one-bit adder area, whatever the operand width.

## Interface
- WIDTH, default 8: operand and result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = add, 1 = subtract; captured with start.
- a  input  WIDTH  operand A; captured with start.
- b  input  WIDTH  operand B; captured with start.
- cin  input  1  carry-in (add) or borrow-in (subtract); captured with start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when the result is complete.
- sum  output  WIDTH  result; held stable from done until the next accepted start.
- carry  output  1  add: carry-out. Subtract: 1 = no borrow.
- overflow  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- Arithmetic, modulo 2^WIDTH:
  - add: sum = a + b + cin.
  - subtract: sum = a + ~b + ~cin, i.e. a − b − cin.
  - Internally the B bit is XORed with sub, and the carry register is initialised to cin XOR sub.
- Registers:
  - A and B shift registers, shifting right.
  - Sum shift register, filling from the MSB end.
  - Carry register.
  - Previous-carry register, used to compute overflow.
  - Bit counter, $clog2(WIDTH) bits wide.
- IDLE:
  - start=1 loads a, b, sub and the initial carry, and clears the counter and the sum register. Next state is RUN.
  - start=0 stays in IDLE.
- RUN, on each edge:
  - the full-adder cell combines A[0], B[0]^sub and the carry register;
  - the sum bit shifts into the sum register;
  - the carry register updates; A and B shift; the counter increments.
  - When the counter reaches WIDTH−1, that edge processes the MSB and the next state is DONE.
- DONE: lasts one cycle, with done=1. carry and overflow are valid. Next state is IDLE.
- start is ignored in RUN and DONE. There is no queuing: a request is lost unless it is held until IDLE.
- Changes on sub, a, b or cin after capture have no effect on the operation in progress.
- Reset is asynchronous and overrides everything, including mid-operation:
  - state returns to IDLE;
  - sum, carry, overflow, busy, done and all internal registers go to 0.
- Reset values: busy=0, done=0, sum=0, carry=0, overflow=0.

## Timing
- start is accepted at edge k. busy=1 from after edge k through edge k+WIDTH.
- Bit i is computed at edge k+1+i.
- done=1 for exactly one cycle, between edges k+WIDTH and k+WIDTH+1.
- Latency from accepting edge to done is WIDTH cycles. Minimum start-to-start spacing is WIDTH+2 cycles.
- start held high continuously is re-accepted in the first IDLE cycle after done.
- sum, carry and overflow update only at the DONE transition. They hold through IDLE until the next accepted start clears sum.
- busy and done are never high together.

## Structure
- Shared package holds:
  - state encodings ST_IDLE, ST_RUN, ST_DONE (2 bits);
  - the WIDTH legal-range check constants.
- One sub-module: full_adder (ports a, b, cin, sum, carry), instantiated once as the serial bit cell. The serial_addsub top contains all sequential logic.
- Target size is about 150–200 lines of RTL, excluding the cell.

## Test plan
All scenarios use WIDTH=8.

- Add: a=0x5A, b=0x3C, cin=0, sub=0. Expected sum=0x96, carry=0, overflow=1, done exactly 8 cycles after the accepting edge.
- Add with wrap: a=0xFF, b=0x01, cin=0. Expected sum=0x00, carry=1, overflow=0. Then a=0xFF, b=0x00, cin=1 gives the same result.
- Subtract: a=0x10, b=0x20, cin=0, sub=1. Expected sum=0xF0, carry=0 (borrow), overflow=0. Then a=0x80, b=0x01 gives sum=0x7F, carry=1, overflow=1.
- Protocol:
  - pulse start with new operands while busy=1 and again during done → ignored, result unchanged;
  - start held high → second operation accepted on the first IDLE cycle; spacing between accepting edges is 10 cycles.
- Operand change after capture: change a/b/sub during RUN → result reflects the values captured at start.
- Reset mid-operation: assert rst_n=0 at bit 4, asynchronously mid-cycle → all outputs 0 immediately, state IDLE. A fresh start after release produces a correct result.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | serial_addsub_pkg : shared state encoding and WIDTH limits       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int c_width_min = 2;
    localparam int c_width_max = 32;

endpackage
`default_nettype wire

// File: rtl/serial_addsub_full_adder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | full_adder : one-bit full-adder cell used as the serial bit slice |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (a & cin) | (b & cin);

endmodule
`default_nettype wire

// File: rtl/serial_addsub.sv
`default_nettype none
// +------------------------------------------------------------------+
// | serial_addsub : bit-serial add/subtract, LSB first, one FA cell   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    generate
        if (WIDTH < c_width_min || WIDTH > c_width_max) begin : g_width_check
            $error("serial_addsub: WIDTH out of range");
        end
    endgenerate

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-2:0]   r_sum_sh;
    logic               r_sub;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_b_bit;
    logic               w_s;
    logic               w_co;
    logic               w_last;
    logic [WIDTH-1:0]   w_sum_cat;

    // Subtraction reuses the adder: B is inverted bitwise and the carry seed is cin^sub.
    assign w_b_bit   = r_b[0] ^ r_sub;
    assign w_last    = (r_cnt == c_last);
    assign w_sum_cat = {w_s, r_sum_sh};

    full_adder u_cell (
        .a     (r_a[0]),
        .b     (w_b_bit),
        .cin   (r_carry),
        .sum   (w_s),
        .carry (w_co)
    );

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_RUN;
            ST_RUN: begin
                busy = 1'b1;
                if (w_last) w_next = ST_DONE;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_sum_sh <= '0;
            r_sub    <= 1'b0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_sub    <= sub;
                        r_carry  <= cin ^ sub;
                        r_cnt    <= '0;
                        r_sum_sh <= '0;
                        sum      <= '0;
                    end
                end
                ST_RUN: begin
                    r_sum_sh <= w_sum_cat[WIDTH-1:1];
                    r_carry  <= w_co;
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    // MSB edge: r_carry is the carry into the MSB, w_co the carry out.
                    if (w_last) begin
                        sum      <= w_sum_cat;
                        carry    <= w_co;
                        overflow <= r_carry ^ w_co;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_serial_addsub : randomized scoreboard bench for serial_addsub  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_serial_addsub;

    localparam int     W    = 8;
    localparam longint MASK = (longint'(1) << W) - 1;
    localparam longint SMAX = (longint'(1) << (W - 1)) - 1;
    localparam longint SMIN = -SMAX - 1;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub   = 1'b0;
    logic         cin   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry;
    logic         overflow;

    typedef struct {
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
        int           acc;
    } exp_t;

    exp_t q_exp[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    serial_addsub #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .carry    (carry),
        .overflow (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer arithmetic, signed range test for overflow.
    function automatic exp_t model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                   input logic fsub, input logic fcin, input int acc);
        exp_t   e;
        longint ua = longint'(fa);
        longint ub = longint'(fb);
        longint sa = $signed(fa);
        longint sb = $signed(fb);
        longint ci = fcin ? 1 : 0;
        longint r;
        longint sr;
        if (!fsub) begin
            r       = ua + ub + ci;
            sr      = sa + sb + ci;
            e.carry = (r > MASK);
        end else begin
            r       = ua - ub - ci;
            sr      = sa - sb - ci;
            e.carry = (r >= 0);
        end
        e.sum = r[W-1:0];
        e.ovf = (sr > SMAX) || (sr < SMIN);
        e.acc = acc;
        return e;
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT signals done.
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy_done_exclusive", longint'(busy && done), 0);
            if (done) begin
                if (q_exp.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done=1, required no result pending");
                end else begin
                    exp_t e;
                    e = q_exp.pop_front();
                    check("sum", longint'(sum), longint'(e.sum));
                    check("carry", longint'(carry), longint'(e.carry));
                    check("overflow", longint'(overflow), longint'(e.ovf));
                    check("latency", longint'(cyc - e.acc), W);
                end
            end else if (q_exp.size() > 0 && cyc > q_exp[0].acc + W + 2) begin
                n_cmp++;
                n_bad++;
                $display("FAIL done_timeout: got no done by cycle %0d, required by %0d",
                         cyc, q_exp[0].acc + W);
                void'(q_exp.pop_front());
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while ((busy || done) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: got busy=%0b done=%0b, required idle", busy, done);
        end
    endtask

    // Issue one operation from IDLE, then scramble the inputs to prove capture.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic isub, input logic icin);
        wait_idle();
        a     = ia;
        b     = ib;
        sub   = isub;
        cin   = icin;
        start = 1'b1;
        q_exp.push_back(model(ia, ib, isub, icin, cyc + 1));
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        sub   = 1'($urandom);
        cin   = 1'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_done"}, longint'(done), 0);
        check({tag, "_sum"}, longint'(sum), 0);
        check({tag, "_carry"}, longint'(carry), 0);
        check({tag, "_overflow"}, longint'(overflow), 0);
    endtask

    initial begin
        exp_t held;
        int   acc1;
        int   t;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        issue(8'h5A, 8'h3C, 1'b0, 1'b0);
        issue(8'hFF, 8'h01, 1'b0, 1'b0);
        issue(8'hFF, 8'h00, 1'b0, 1'b1);
        issue(8'h10, 8'h20, 1'b1, 1'b0);
        issue(8'h80, 8'h01, 1'b1, 1'b0);

        // Start pulses during RUN and during DONE must be dropped.
        issue(8'h12, 8'h34, 1'b0, 1'b0);
        held = model(8'h12, 8'h34, 1'b0, 1'b0, 0);
        repeat (3) @(negedge clk);
        a = 8'hAA; b = 8'h55; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (!done && t < 20) begin
            @(negedge clk);
            t++;
        end
        a = 8'h77; b = 8'h11; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("ignored_start_sum", longint'(sum), longint'(held.sum));
        check("ignored_start_busy", longint'(busy), 0);

        // Held start: re-accepted on the first IDLE cycle, operands swapped mid-run.
        wait_idle();
        a = 8'h7F; b = 8'h01; sub = 1'b0; cin = 1'b0; start = 1'b1;
        acc1 = cyc + 1;
        q_exp.push_back(model(8'h7F, 8'h01, 1'b0, 1'b0, acc1));
        @(posedge clk);
        #1;
        @(negedge clk);
        @(negedge clk);
        a = 8'h03; b = 8'h05; sub = 1'b1; cin = 1'b1;
        q_exp.push_back(model(8'h03, 8'h05, 1'b1, 1'b1, acc1 + W + 2));
        repeat (9) @(posedge clk);
        #1;
        start = 1'b0;

        // Asynchronous reset in the middle of an operation.
        issue(8'hC3, 8'h5A, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        q_exp.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(8'h64, 8'h9C, 1'b1, 1'b1);

        for (int i = 0; i < 40; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end

        t = 0;
        while (q_exp.size() > 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (q_exp.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d results outstanding, required 0", q_exp.size());
        end
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
